fifo_readout_sched: RTL

//  Per-event readout sequencer for the seven DMB source FIFOs (CFEB1-5, TMB, ALCT).

---
 rtl/dmb_rd_pkg.sv | 26 ++
 rtl/prio_enc7.sv | 22 ++
 rtl/fifo_readout_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmb_rd_pkg.sv
// rtl/dmb_rd_pkg.sv - shared constants and FSM state type for the DMB FIFO readout sequencer
package dmb_rd_pkg;

  localparam int NSRC = 7;

  // Source index constants; bit position in every per-source mask
  localparam logic [2:0] SRC_CFEB1 = 3'd0;
  localparam logic [2:0] SRC_CFEB2 = 3'd1;
  localparam logic [2:0] SRC_CFEB3 = 3'd2;
  localparam logic [2:0] SRC_CFEB4 = 3'd3;
  localparam logic [2:0] SRC_CFEB5 = 3'd4;
  localparam logic [2:0] SRC_TMB   = 3'd5;
  localparam logic [2:0] SRC_ALCT  = 3'd6;

  // Idle cycles allowed per source before it is abandoned
  localparam logic [8:0] TMO_DEF = 9'd40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SELECT,
    ST_XFER,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/prio_enc7.sv
// rtl/prio_enc7.sv - lowest-set-bit encoder over the seven source pending bits
module prio_enc7
  import dmb_rd_pkg::*;
(
  input  logic [NSRC-1:0] req,
  output logic [2:0]      idx,
  output logic            none
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx  = 3'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_readout_sched.sv
// rtl/fifo_readout_sched.sv - per-event readout sequencer for the seven DMB source FIFOs
module fifo_readout_sched
  import dmb_rd_pkg::*;
#(
  parameter logic [8:0] TMO = TMO_DEF
) (
  input  logic            CLKCMS,
  input  logic            RST,
  input  logic            FIFOMRST,
  input  logic            GEMPTY_B,
  input  logic [NSRC-1:0] DAVMASK,
  input  logic [NSRC-1:0] KILL,
  output logic            POPQ,
  input  logic [NSRC-1:0] FFOR_B,
  input  logic [17:0]     DATAIN,
  input  logic            DOUT_RDY,
  output logic [NSRC-1:0] OEFIFO_B,
  output logic [NSRC-1:0] RENFIFO_B,
  output logic [15:0]     DOUT,
  output logic            DV,
  output logic [2:0]      SRC,
  output logic            LAST,
  output logic [NSRC-1:0] TMO_FLAGS,
  output logic            EVT_DONE,
  output logic            BUSY
);

  rd_state_t       state;
  logic [NSRC-1:0] pend;
  logic [2:0]      cur;
  logic [8:0]      tmo_cnt;
  logic [2:0]      enc_idx;
  logic            enc_none;
  logic [NSRC-1:0] cur_onehot;
  logic            pop;
  logic            unused_datain16;

  // Bit 16 of the FIFO word carries no meaning for the packer
  assign unused_datain16 = DATAIN[16];

  prio_enc7 u_prio (
    .req  (pend),
    .idx  (enc_idx),
    .none (enc_none)
  );

  // A word moves only when the selected FIFO has one and the packer can take it
  assign cur_onehot = NSRC'(1) << cur;
  assign pop        = (state == ST_XFER) && !FFOR_B[cur] && DOUT_RDY;
  assign RENFIFO_B  = pop ? ~cur_onehot : '1;

  // Sequencer FSM with timeout counter and registered outputs; FIFOMRST aborts like a reset
  always_ff @(posedge CLKCMS or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      pend      <= '0;
      cur       <= '0;
      tmo_cnt   <= '0;
      POPQ      <= 1'b0;
      OEFIFO_B  <= '1;
      DOUT      <= '0;
      DV        <= 1'b0;
      SRC       <= '0;
      LAST      <= 1'b0;
      TMO_FLAGS <= '0;
      EVT_DONE  <= 1'b0;
      BUSY      <= 1'b0;
    end else if (FIFOMRST) begin
      state     <= ST_IDLE;
      pend      <= '0;
      cur       <= '0;
      tmo_cnt   <= '0;
      POPQ      <= 1'b0;
      OEFIFO_B  <= '1;
      DOUT      <= '0;
      DV        <= 1'b0;
      SRC       <= '0;
      LAST      <= 1'b0;
      TMO_FLAGS <= '0;
      EVT_DONE  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      POPQ     <= 1'b0;
      EVT_DONE <= 1'b0;
      DV       <= 1'b0;
      LAST     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (GEMPTY_B) begin
            state <= ST_LOAD;
            POPQ  <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        ST_LOAD: begin
          pend      <= DAVMASK & ~KILL;
          TMO_FLAGS <= '0;
          state     <= ST_SELECT;
        end
        ST_SELECT: begin
          tmo_cnt <= '0;
          cur     <= enc_idx;
          if (enc_none) begin
            state    <= ST_DONE;
            EVT_DONE <= 1'b1;
          end else begin
            state    <= ST_XFER;
            OEFIFO_B <= ~(NSRC'(1) << enc_idx);
          end
        end
        ST_XFER: begin
          if (pop) begin
            DOUT    <= DATAIN[15:0];
            DV      <= 1'b1;
            SRC     <= cur;
            LAST    <= DATAIN[17];
            tmo_cnt <= '0;
            // A last word popped on the terminal count still ends the block cleanly
            if (DATAIN[17]) begin
              pend[cur] <= 1'b0;
              OEFIFO_B  <= '1;
              state     <= ST_SELECT;
            end
          end else if (tmo_cnt == TMO - 9'd1) begin
            TMO_FLAGS[cur] <= 1'b1;
            pend[cur]      <= 1'b0;
            OEFIFO_B       <= '1;
            state          <= ST_SELECT;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 9'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
